// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t : receiver FSM state encoding
//   PAR_EVEN / PAR_ODD : Par_Typ encoding, identical to the transmit side
//   PRESC_MIN : smallest usable oversampling ratio (smaller Prescale is clamped)
//   DATA_WIDTH_DEF : default payload width
//   majority3() : 2-of-3 vote used by the bit sampler
package uart_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned PRESC_MIN      = 4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4,
        StDone   = 3'd5
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-point majority sampler.
//   clk, rst_n       : clock, asynchronous active-low reset
//   rxs_i            : synchronised serial line
//   start_i          : start edge seen this cycle (counter restarts at 1)
//   run_i            : a frame bit is in progress (counter advances)
//   presc_i          : clocks per bit, already clamped and latched
//   sample_bit_o     : majority of the samples at S0, S1 and the live S2 value
//   sample_strobe_o  : counter is at S2, sample_bit_o is meaningful
//   bit_end_o        : counter is at P-1, last clock of the current bit
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rxs_i,
    input  logic               start_i,
    input  logic               run_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               sample_bit_o,
    output logic               sample_strobe_o,
    output logic               bit_end_o
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic [PRESC_W-1:0] pt_s0, pt_s1, pt_s2, pt_last;
    logic               s0_q, s0_d;
    logic               s1_q, s1_d;

    always_comb begin
        pt_s1   = presc_i >> 1;
        pt_s0   = pt_s1 - PRESC_W'(1);
        pt_s2   = pt_s1 + PRESC_W'(1);
        pt_last = presc_i - PRESC_W'(1);
    end

    assign bit_end_o       = run_i && (cnt_q == pt_last);
    assign sample_strobe_o = run_i && (cnt_q == pt_s2);
    // Third vote is taken live at S2 so the bit value is usable in the same cycle.
    assign sample_bit_o    = majority3(s0_q, s1_q, rxs_i);

    always_comb begin
        cnt_d = '0;
        s0_d  = s0_q;
        s1_d  = s1_q;
        // The detect cycle itself is count 0 of the start bit, so the next cycle is 1.
        if (start_i) begin
            cnt_d = PRESC_W'(1);
        end else if (run_i) begin
            cnt_d = bit_end_o ? '0 : cnt_q + PRESC_W'(1);
        end
        if (run_i && (cnt_q == pt_s0)) s0_d = rxs_i;
        if (run_i && (cnt_q == pt_s1)) s1_d = rxs_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            s0_q  <= 1'b1;
            s1_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            s0_q  <= s0_d;
            s1_q  <= s1_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start, DATA_WIDTH bits LSB first, optional parity, stop.
//   clk, rst_n  : clock, asynchronous active-low reset
//   RX_IN       : asynchronous serial line, idles high
//   Prescale    : clocks per bit (values below PRESC_MIN are treated as PRESC_MIN)
//   Par_En      : parity bit present and checked
//   Par_Typ     : 0 even, 1 odd
//   P_DATA      : last byte received without error
//   Data_Valid  : 1-cycle pulse, P_DATA updated
//   Par_Err     : 1-cycle pulse, parity mismatch
//   Stp_Err     : 1-cycle pulse, stop bit sampled low
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_t state_q, state_d;

    logic                  rx_meta_q, rxs_q, rxs_prev_q;
    logic [PRESC_W-1:0]    presc_q, presc_d, presc_eff;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  par_bad_q, par_bad_d;
    logic                  stop_bad_q, stop_bad_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic start_det, run;
    logic sample_bit, sample_strobe, bit_end;
    logic idx_last;

    // Two-flop synchroniser plus one history flop for 1->0 edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= RX_IN;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Requires a real falling edge, so a line held low (break) never re-triggers.
    assign start_det = (state_q == StIdle) && rxs_prev_q && !rxs_q;
    assign run       = (state_q == StStart) || (state_q == StData) ||
                       (state_q == StParity) || (state_q == StStop);
    assign presc_eff = (Prescale < PRESC_W'(PRESC_MIN)) ? PRESC_W'(PRESC_MIN) : Prescale;
    assign idx_last  = (idx_q == IDX_W'(DATA_WIDTH - 1));

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk             (clk),
        .rst_n           (rst_n),
        .rxs_i           (rxs_q),
        .start_i         (start_det),
        .run_i           (run),
        .presc_i         (presc_q),
        .sample_bit_o    (sample_bit),
        .sample_strobe_o (sample_strobe),
        .bit_end_o       (bit_end)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_det) state_d = StStart;
            end
            StStart: begin
                // Start bit that votes high at mid-bit is a glitch: drop it silently.
                if (sample_strobe && sample_bit) begin
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end && idx_last) state_d = par_en_q ? StParity : StStop;
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                // Leave mid stop bit so a back-to-back start edge is not missed.
                if (sample_strobe) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        if (start_det) begin
            presc_d    = presc_eff;
            par_en_d   = Par_En;
            par_typ_d  = Par_Typ;
            idx_d      = '0;
            par_bad_d  = 1'b0;
            stop_bad_d = 1'b0;
        end

        case (state_q)
            StData: begin
                if (sample_strobe) shift_d[idx_q] = sample_bit;
                if (bit_end) idx_d = idx_q + IDX_W'(1);
            end
            StParity: begin
                if (sample_strobe) begin
                    par_bad_d = sample_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD));
                end
            end
            StStop: begin
                if (sample_strobe) stop_bad_d = !sample_bit;
            end
            StDone: begin
                pe_d = par_bad_q;
                se_d = stop_bad_q;
                if (!par_bad_q && !stop_bad_q) begin
                    dv_d     = 1'b1;
                    p_data_d = shift_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= PRESC_W'(PRESC_MIN);
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            shift_q    <= '0;
            idx_q      <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = dv_q;
    assign Par_Err    = pe_q;
    assign Stp_Err    = se_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: drives serial frames, counts output pulses and
// logs received bytes, checks against hand-computed expectations.
module tb_uart_rx_core;

    logic       clk;
    logic       rst_n;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       Par_En;
    logic       Par_Typ;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    int n_checks = 0;
    int n_errors = 0;

    int         cyc = 0;
    int         n_dv = 0;
    int         n_pe = 0;
    int         n_se = 0;
    int         dv_cyc = 0;
    int         stop_cyc = 0;
    logic [7:0] rx_log[$];

    uart_rx_core #(
        .DATA_WIDTH (8),
        .PRESC_W    (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .Par_En     (Par_En),
        .Par_Typ    (Par_Typ),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (Data_Valid) begin
            n_dv   <= n_dv + 1;
            dv_cyc <= cyc;
            rx_log.push_back(P_DATA);
        end
        if (Par_Err) n_pe <= n_pe + 1;
        if (Stp_Err) n_se <= n_se + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic line(input logic v, input int n);
        RX_IN = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; leaves RX_IN at the stop-bit value on return.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic ptyp, input logic pflip, input logic stop,
                              input int gl_bit, input int gl_off);
        logic [10:0] bits;
        int          nb;
        Prescale = 6'(p);
        Par_En   = pen;
        Par_Typ  = ptyp;
        bits     = '1;
        bits[0]  = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        nb = 9;
        if (pen) begin
            bits[9] = (^d) ^ ptyp ^ pflip;
            nb      = 10;
        end
        bits[nb] = stop;
        for (int b = 0; b <= nb; b++) begin
            if (b == nb) stop_cyc = cyc;
            for (int c = 0; c < p; c++) begin
                RX_IN = (b == gl_bit && c == gl_off) ? ~bits[b] : bits[b];
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        Par_En   = 1'b0;
        Par_Typ  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pdata", P_DATA, 8'h00);
        check("reset_dv", Data_Valid, 1'b0);
        check("reset_pe", Par_Err, 1'b0);
        check("reset_se", Stp_Err, 1'b0);
        rst_n = 1'b1;
        line(1'b1, 10);

        // 1: P=8, no parity, 0xA5.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        line(1'b1, 20);
        check("t1_dv_count", n_dv, 1);
        check("t1_data", rx_log[0], 8'hA5);
        check("t1_pdata", P_DATA, 8'hA5);
        check("t1_pe_count", n_pe, 0);
        check("t1_se_count", n_se, 0);
        check("t1_latency", dv_cyc - stop_cyc, 8 / 2 + 5);

        // 2: P=16, even parity, 0x3C good then bad parity.
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
        line(1'b1, 30);
        check("t2_dv_count", n_dv, 2);
        check("t2_data", rx_log[1], 8'h3C);
        check("t2_pe_none", n_pe, 0);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0);
        line(1'b1, 30);
        check("t2_pe_count", n_pe, 1);
        check("t2_dv_held", n_dv, 2);
        check("t2_se_none", n_se, 0);
        check("t2_pdata_hold", P_DATA, 8'h3C);

        // 3: P=8, 0x55 with stop bit low, break, then 0x12.
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
        line(1'b0, 40);
        line(1'b1, 40);
        check("t3_se_count", n_se, 1);
        check("t3_dv_none", n_dv, 2);
        check("t3_pe_none", n_pe, 1);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        line(1'b1, 20);
        check("t3_dv_count", n_dv, 3);
        check("t3_data", rx_log[2], 8'h12);

        // 4: P=16, 2-clock glitch on idle line, then 0xFF with a 1-clock dip at S1.
        Prescale = 6'd16;
        line(1'b0, 2);
        line(1'b1, 250);
        check("t4_glitch_dv", n_dv, 3);
        check("t4_glitch_se", n_se, 1);
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, 4, 8);
        line(1'b1, 30);
        check("t4_dv_count", n_dv, 4);
        check("t4_data", rx_log[3], 8'hFF);

        // 5: P=32, odd parity, 0x00 and 0xFF back to back.
        send_frame(8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
        send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
        line(1'b1, 50);
        check("t5_dv_count", n_dv, 6);
        check("t5_data0", rx_log[4], 8'h00);
        check("t5_data1", rx_log[5], 8'hFF);
        check("t5_pe_none", n_pe, 1);
        check("t5_se_none", n_se, 1);
        check("t5_latency", dv_cyc - stop_cyc, 32 / 2 + 5);

        // 6: reset in the middle of the data bits, then 0x81.
        Prescale = 6'd8;
        Par_En   = 1'b0;
        line(1'b0, 8);
        line(1'b1, 8);
        line(1'b0, 8);
        line(1'b1, 4);
        rst_n = 1'b0;
        #1;
        check("t6_rst_pdata", P_DATA, 8'h00);
        check("t6_rst_dv", Data_Valid, 1'b0);
        RX_IN = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        line(1'b1, 100);
        check("t6_no_pulse", n_dv + n_pe + n_se, 6 + 1 + 1);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        line(1'b1, 20);
        check("t6_dv_count", n_dv, 7);
        check("t6_data", rx_log[6], 8'h81);
        check("t6_pdata", P_DATA, 8'h81);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
